// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
//   Round-robin arbiter that shares one WIDTH-bit register between NREQ
//   requesters. The arbiter grants one requester at a time. The granted
//   requester's data is captured into the shared register at the edge where
//   it still holds its request. The owner can hold the grant across
//   back-to-back writes by keeping its lock bit set.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req       in   [NREQ]       per-requester request (level, held until serviced)
//   lock      in   [NREQ]       per-requester hold, only looked at for the owner
//   wdata     in   [NREQ*WIDTH] requester i data on [i*WIDTH +: WIDTH]
//   gnt       out  [NREQ]       registered one-hot grant, zero when idle
//   owner     out  [IDXW]       index of the current / last granted requester
//   wr_valid  out  1            q was updated at the preceding edge
//   q         out  [WIDTH]      shared register contents
//
// Handshake: a requester raises req with stable wdata and keeps both until it
// sees its gnt bit. The write happens at the first edge where gnt[i] and
// req[i] are both high. Dropping req while granted withdraws the request
// without a write.
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDXW  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        lock,
   input  logic [NREQ*WIDTH-1:0]  wdata,
   output logic [NREQ-1:0]        gnt,
   output logic [IDXW-1:0]        owner,
   output logic                   wr_valid,
   output logic [WIDTH-1:0]       q
);

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t            state;
   logic [IDXW-1:0]   ptr;

   logic              serviced;
   logic [IDXW-1:0]   base;
   logic [NREQ-1:0]   arb_req;
   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;
   logic [NREQ-1:0]   pick_onehot;
   logic [WIDTH-1:0]  owner_data;

   // Arbitration for the coming edge.
   always_comb begin
      serviced    = (state == S_OWNED) && req[owner];
      owner_data  = wdata[int'(owner)*WIDTH +: WIDTH];
      // While owned, the scan starts after the current owner because ptr is
      // updated to the owner at the same edge the next owner is chosen.
      base        = (state == S_OWNED) ? owner : ptr;
      // The request is consumed by the write at this edge. It must not win the
      // re-arbitration that happens at the same edge.
      arb_req     = req;
      if (serviced) begin
         arb_req[owner] = 1'b0;
      end
      pick_found  = 1'b0;
      pick_idx    = '0;
      // First scan the positions above base, then wrap to 0..base.
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_found && (i > int'(base)) && arb_req[i]) begin
            pick_found = 1'b1;
            pick_idx   = IDXW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_found && (i <= int'(base)) && arb_req[i]) begin
            pick_found = 1'b1;
            pick_idx   = IDXW'(i);
         end
      end
      pick_onehot = '0;
      pick_onehot[pick_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         gnt      <= '0;
         owner    <= '0;
         wr_valid <= 1'b0;
         q        <= '0;
         ptr      <= IDXW'(NREQ-1);
      end else begin
         wr_valid <= serviced;
         if (serviced) begin
            q <= owner_data;
         end
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  gnt   <= pick_onehot;
                  owner <= pick_idx;
                  state <= S_OWNED;
               end
            end
            S_OWNED: begin
               // A locked owner keeps the register only while it is writing.
               // Withdrawing req releases it even with lock set.
               if (!(serviced && lock[owner])) begin
                  ptr <= owner;
                  if (pick_found) begin
                     gnt   <= pick_onehot;
                     owner <= pick_idx;
                  end else begin
                     gnt   <= '0;
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               gnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_arbiter
//   Directed bench for shared_reg_arbiter. It drives a default 4x8 instance
//   and a 2x16 instance from one linear sequence of steps. Every expected
//   value is written out by hand.
// -----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // default build: NREQ=4, WIDTH=8
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        wr_valid;
   logic [7:0]  q;

   shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .wdata(wdata),
      .gnt(gnt), .owner(owner), .wr_valid(wr_valid), .q(q)
   );

   // NREQ=2, WIDTH=16 build
   logic [1:0]  req_b;
   logic [1:0]  lock_b;
   logic [31:0] wdata_b;
   logic [1:0]  gnt_b;
   logic [0:0]  owner_b;
   logic        wr_valid_b;
   logic [15:0] q_b;

   shared_reg_arbiter #(.NREQ(2), .WIDTH(16), .IDXW(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .lock(lock_b), .wdata(wdata_b),
      .gnt(gnt_b), .owner(owner_b), .wr_valid(wr_valid_b), .q(q_b)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                       input logic ew, input logic [7:0] eq);
      chk({tag, ".gnt"},      32'(gnt),      32'(eg));
      chk({tag, ".owner"},    32'(owner),    32'(eo));
      chk({tag, ".wr_valid"}, 32'(wr_valid), 32'(ew));
      chk({tag, ".q"},        32'(q),        32'(eq));
   endtask

   task automatic chk2(input string tag, input logic [1:0] eg, input logic eo,
                       input logic ew, input logic [15:0] eq);
      chk({tag, ".gnt"},      32'(gnt_b),      32'(eg));
      chk({tag, ".owner"},    32'(owner_b),    32'(eo));
      chk({tag, ".wr_valid"}, 32'(wr_valid_b), 32'(ew));
      chk({tag, ".q"},        32'(q_b),        32'(eq));
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = '0;
      lock    = '0;
      wdata   = '0;
      req_b   = '0;
      lock_b  = '0;
      wdata_b = '0;
      #12;
      chk4("reset", 4'b0000, 2'd0, 1'b0, 8'h00);
      chk2("reset_b", 2'b00, 1'b0, 1'b0, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      // single request from idle: gnt in cycle 1, write visible in cycle 2
      req   = 4'b0001;
      wdata = 32'h0000_00A5;
      step();
      chk4("single.c1", 4'b0001, 2'd0, 1'b0, 8'h00);
      step();
      chk4("single.c2", 4'b0000, 2'd0, 1'b1, 8'hA5);
      req = 4'b0000;
      step();
      chk4("single.c3", 4'b0000, 2'd0, 1'b0, 8'hA5);

      // all four requesting. ptr is now 0, so the rotation starts at 1.
      req   = 4'b1111;
      wdata = 32'h4433_2211;
      step();
      chk4("rot.1", 4'b0010, 2'd1, 1'b0, 8'hA5);
      step();
      chk4("rot.2", 4'b0100, 2'd2, 1'b1, 8'h22);
      step();
      chk4("rot.3", 4'b1000, 2'd3, 1'b1, 8'h33);
      step();
      chk4("rot.4", 4'b0001, 2'd0, 1'b1, 8'h44);
      step();
      chk4("rot.5", 4'b0010, 2'd1, 1'b1, 8'h11);
      req = 4'b0000;
      step();
      chk4("rot.withdraw", 4'b0000, 2'd1, 1'b0, 8'h11);

      // lock: owner 1 keeps the register for three writes while 2 waits
      req   = 4'b0010;
      lock  = 4'b0010;
      wdata = 32'h00BB_A100;
      step();
      chk4("lock.grant", 4'b0010, 2'd1, 1'b0, 8'h11);
      req = 4'b0110;
      step();
      chk4("lock.w1", 4'b0010, 2'd1, 1'b1, 8'hA1);
      wdata = 32'h00BB_A200;
      step();
      chk4("lock.w2", 4'b0010, 2'd1, 1'b1, 8'hA2);
      wdata = 32'h00BB_A300;
      step();
      chk4("lock.w3", 4'b0010, 2'd1, 1'b1, 8'hA3);
      lock  = 4'b0000;
      wdata = 32'h00BB_A400;
      step();
      chk4("lock.release", 4'b0100, 2'd2, 1'b1, 8'hA4);
      req  = 4'b0100;
      lock = 4'b1000;   // lock on a non-owner is ignored
      step();
      chk4("lock.next", 4'b0000, 2'd2, 1'b1, 8'hBB);
      req  = 4'b0000;
      lock = 4'b0000;
      step();
      chk4("lock.idle", 4'b0000, 2'd2, 1'b0, 8'hBB);

      // withdraw while granted, with another requester pending
      req   = 4'b0100;
      wdata = 32'h00CC_0000;
      step();
      chk4("wd.grant", 4'b0100, 2'd2, 1'b0, 8'hBB);
      req   = 4'b0001;
      wdata = 32'h00CC_00DD;
      step();
      chk4("wd.pass", 4'b0001, 2'd0, 1'b0, 8'hBB);
      step();
      chk4("wd.write0", 4'b0000, 2'd0, 1'b1, 8'hDD);
      // withdraw with nobody else pending goes idle
      req = 4'b0010;
      step();
      chk4("wd2.grant", 4'b0010, 2'd1, 1'b0, 8'hDD);
      req = 4'b0000;
      step();
      chk4("wd2.idle", 4'b0000, 2'd1, 1'b0, 8'hDD);

      // asynchronous reset in the middle of a rotation
      req   = 4'b1111;
      wdata = 32'h4433_2211;
      step();
      chk4("mid.1", 4'b0100, 2'd2, 1'b0, 8'hDD);
      step();
      chk4("mid.2", 4'b1000, 2'd3, 1'b1, 8'h33);
      #2;
      rst_n = 1'b0;
      #1;
      chk4("mid.async", 4'b0000, 2'd0, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk4("mid.after", 4'b0001, 2'd0, 1'b0, 8'h00);
      step();
      chk4("mid.after2", 4'b0010, 2'd1, 1'b1, 8'h11);
      req = 4'b0000;
      step();
      step();

      // 2-requester, 16-bit build
      req_b   = 2'b11;
      wdata_b = 32'hBEEF_1234;
      step();
      chk2("b.1", 2'b01, 1'b0, 1'b0, 16'h0000);
      step();
      chk2("b.2", 2'b10, 1'b1, 1'b1, 16'h1234);
      req_b = 2'b10;
      step();
      chk2("b.3", 2'b00, 1'b1, 1'b1, 16'hBEEF);
      req_b   = 2'b01;
      wdata_b = 32'hBEEF_5A5A;
      step();
      chk2("b.4", 2'b01, 1'b0, 1'b0, 16'hBEEF);
      step();
      chk2("b.5", 2'b00, 1'b0, 1'b1, 16'h5A5A);
      req_b   = 2'b10;
      wdata_b = 32'hC3C3_5A5A;
      step();
      chk2("b.6", 2'b10, 1'b1, 1'b0, 16'h5A5A);
      step();
      chk2("b.7", 2'b00, 1'b1, 1'b1, 16'hC3C3);
      req_b = 2'b00;
      step();
      chk2("b.8", 2'b00, 1'b1, 1'b0, 16'hC3C3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
